// File: rtl/sobel_feeder_pkg.sv
// Shared constants and types for the sobel_feeder stream-to-window block.
package sobel_feeder_pkg;

    localparam int IMG_WIDTH_DEF   = 32;
    localparam int IMG_HEIGHT_DEF  = 24;
    localparam int PIXEL_WIDTH_DEF = 8;

    // Strobes per window: full 3x3 at row start, new column afterwards.
    localparam int N_LEAD = 9;
    localparam int N_COL  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_LEAD,
        ST_EMIT,
        ST_GAP
    } feeder_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Rows r-1 and r-2 plus the row being filled; rotates on demand and
// exposes columns c-2, c-1, c of both stored rows combinationally.
module sobel_line_buffer #(
    parameter int IMG_WIDTH   = 32,
    parameter int PIXEL_WIDTH = 8,
    parameter int CW          = $clog2(IMG_WIDTH)
) (
    input  logic                        clk_i,
    input  logic                        wr_en,
    input  logic [CW-1:0]               wr_col,
    input  logic [PIXEL_WIDTH-1:0]      wr_px,
    input  logic                        rotate,
    input  logic [CW-1:0]               rd_col,
    output logic [2:0][PIXEL_WIDTH-1:0] top,
    output logic [2:0][PIXEL_WIDTH-1:0] mid
);

    logic [PIXEL_WIDTH-1:0] cur_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r1_q  [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r2_q  [IMG_WIDTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) cur_q[wr_col] <= wr_px;
    end

    // Storage is not reset: the two fill rows of every frame overwrite it.
    always_ff @(posedge clk_i) begin
        if (rotate) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                r1_q[i] <= cur_q[i];
                r2_q[i] <= r1_q[i];
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_rd
        logic [CW-1:0] c;
        assign c      = rd_col + CW'(k) - CW'(2);
        assign top[k] = r2_q[c];
        assign mid[k] = r1_q[c];
    end

endmodule

// File: rtl/sobel_feeder.sv
// Raster grayscale stream to serialized 3x3 window strobes for sobel_control.
// Optional SOBEL_FEEDER_ABORT_EN: frame_start_i outside IDLE restarts the frame.
module sobel_feeder
    import sobel_feeder_pkg::*;
#(
    parameter int IMG_WIDTH       = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT      = IMG_HEIGHT_DEF,
    parameter int PIXEL_WIDTH_OUT = PIXEL_WIDTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic                       frame_start_i,
    input  logic                       px_valid_i,
    input  logic [PIXEL_WIDTH_OUT-1:0] px_i,
    output logic                       px_ready_o,
    output logic                       start_sobel_o,
    output logic                       px_rdy_o,
    output logic [PIXEL_WIDTH_OUT-1:0] out_px_o,
    output logic                       frame_done_o
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    feeder_state_t state_q, state_d;

    logic [CW-1:0] col_q, win_col_q;
    logic [RW-1:0] row_q;
    logic [3:0]    idx_q, sel;
    logic          last_col_q, last_row_q, full_q, gap_q, rot_q;
    logic          restart, accept, win_hit, emit_last, rotate;

    logic [PIXEL_WIDTH_OUT-1:0]      cur_q, sh_a_q, sh_b_q;
    logic [2:0][PIXEL_WIDTH_OUT-1:0] top, mid;
    logic [8:0][PIXEL_WIDTH_OUT-1:0] win;

`ifdef SOBEL_FEEDER_ABORT_EN
    assign restart = frame_start_i;
`else
    assign restart = frame_start_i && (state_q == ST_IDLE);
`endif

    assign accept    = px_valid_i && px_ready_o && !restart;
    assign win_hit   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign emit_last = idx_q == (full_q ? 4'(N_LEAD - 1) : 4'(N_COL - 1));
    // Fill rows rotate right after their last pixel; window rows wait
    // until the burst reading them has drained.
    assign rotate    = rot_q || ((state_q == ST_GAP) && gap_q);
    assign win       = {cur_q, sh_b_q, sh_a_q, mid, top};

    always_comb begin
        sel = idx_q;
        if (!full_q) begin
            case (idx_q)
                4'd0:    sel = 4'd2;
                4'd1:    sel = 4'd5;
                default: sel = 4'd8;
            endcase
        end
    end

    sobel_line_buffer #(
        .IMG_WIDTH   (IMG_WIDTH),
        .PIXEL_WIDTH (PIXEL_WIDTH_OUT)
    ) u_lb (
        .clk_i  (clk_i),
        .wr_en  (accept),
        .wr_col (col_q),
        .wr_px  (px_i),
        .rotate (rotate),
        .rd_col (win_col_q),
        .top    (top),
        .mid    (mid)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_ACCEPT;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ACCEPT: if (accept && win_hit)
                               state_d = (col_q == CW'(2)) ? ST_LEAD : ST_EMIT;
                ST_LEAD:   state_d = ST_EMIT;
                ST_EMIT:   if (emit_last)
                               state_d = last_col_q ? ST_GAP : ST_ACCEPT;
                ST_GAP:    if (gap_q)
                               state_d = last_row_q ? ST_IDLE : ST_ACCEPT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            px_ready_o    <= 1'b0;
            start_sobel_o <= 1'b0;
            px_rdy_o      <= 1'b0;
            out_px_o      <= '0;
            frame_done_o  <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            win_col_q     <= '0;
            idx_q         <= '0;
            last_col_q    <= 1'b0;
            last_row_q    <= 1'b0;
            full_q        <= 1'b0;
            gap_q         <= 1'b0;
            rot_q         <= 1'b0;
            cur_q         <= '0;
            sh_a_q        <= '0;
            sh_b_q        <= '0;
        end else begin
            px_ready_o   <= (state_d == ST_ACCEPT);
            px_rdy_o     <= 1'b0;
            frame_done_o <= 1'b0;
            rot_q        <= 1'b0;
            if (restart) begin
                col_q         <= '0;
                row_q         <= '0;
                idx_q         <= '0;
                gap_q         <= 1'b0;
                start_sobel_o <= 1'b0;
            end else begin
                if (accept) begin
                    win_col_q  <= col_q;
                    last_col_q <= (col_q == CW'(IMG_WIDTH - 1));
                    last_row_q <= (row_q == RW'(IMG_HEIGHT - 1));
                    full_q     <= (col_q == CW'(2));
                    idx_q      <= '0;
                    gap_q      <= 1'b0;
                    sh_a_q     <= sh_b_q;
                    sh_b_q     <= cur_q;
                    cur_q      <= px_i;
                    if (col_q == CW'(IMG_WIDTH - 1)) begin
                        col_q <= '0;
                        row_q <= (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
                        rot_q <= !win_hit;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                unique case (state_q)
                    ST_IDLE: start_sobel_o <= 1'b0;
                    ST_LEAD: start_sobel_o <= 1'b1;
                    ST_EMIT: begin
                        px_rdy_o <= 1'b1;
                        out_px_o <= win[sel];
                        idx_q    <= idx_q + 1'b1;
                    end
                    ST_GAP: begin
                        start_sobel_o <= 1'b0;
                        gap_q         <= 1'b1;
                        frame_done_o  <= gap_q && last_row_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sobel_feeder.sv
// Directed bench for sobel_feeder: 4x3 and 5x4 frames, stalls, reset, restart.
module tb_sobel_feeder;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       fs_a = 1'b0;
    logic       fs_b = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] px = '0;
    logic       sel = 1'b0;

    logic       a_ready, a_start, a_rdy, a_done;
    logic       b_ready, b_start, b_rdy, b_done;
    logic [7:0] a_out, b_out;
    logic       cur_ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign cur_ready = sel ? b_ready : a_ready;

    sobel_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .PIXEL_WIDTH_OUT(8)) u_a (
        .clk_i         (clk),
        .nreset_i      (nreset),
        .frame_start_i (fs_a),
        .px_valid_i    (valid),
        .px_i          (px),
        .px_ready_o    (a_ready),
        .start_sobel_o (a_start),
        .px_rdy_o      (a_rdy),
        .out_px_o      (a_out),
        .frame_done_o  (a_done)
    );

    sobel_feeder #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .PIXEL_WIDTH_OUT(8)) u_b (
        .clk_i         (clk),
        .nreset_i      (nreset),
        .frame_start_i (fs_b),
        .px_valid_i    (valid),
        .px_i          (px),
        .px_ready_o    (b_ready),
        .start_sobel_o (b_start),
        .px_rdy_o      (b_rdy),
        .out_px_o      (b_out),
        .frame_done_o  (b_done)
    );

    int   qa[$];
    int   qb[$];
    int   cyc = 0;
    int   a_rise = 0, a_done_n = 0, a_bad = 0, a_lat = -1, a_ts = 0;
    bit   a_pend = 1'b0, a_prev = 1'b0;
    int   b_rise = 0, b_done_n = 0, b_min = 1000, b_run = 0;
    bit   b_seen = 1'b0, b_prev = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        a_prev <= a_start;
        if (a_start && !a_prev) begin
            a_rise <= a_rise + 1;
            a_ts   <= cyc;
            a_pend <= 1'b1;
        end
        if (a_rdy) begin
            qa.push_back(int'(a_out));
            if (!a_start) a_bad <= a_bad + 1;
            if (a_pend) begin
                a_lat  <= cyc - a_ts;
                a_pend <= 1'b0;
            end
        end
        if (a_done) a_done_n <= a_done_n + 1;
    end

    always @(negedge clk) begin
        b_prev <= b_start;
        if (b_start) begin
            if (!b_prev) b_rise <= b_rise + 1;
            if (!b_prev && b_seen && b_run < b_min) b_min <= b_run;
            b_run  <= 0;
            b_seen <= 1'b1;
        end else begin
            b_run <= b_run + 1;
        end
        if (b_rdy) qb.push_back(int'(b_out));
        if (b_done) b_done_n <= b_done_n + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void build(input int w, input int h, input int base,
                                  output int q[$]);
        q = {};
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++)
                if (c == 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            q.push_back(base + (r - 2 + i) * w + c - 2 + j);
                end else begin
                    for (int i = 0; i < 3; i++)
                        q.push_back(base + (r - 2 + i) * w + c);
                end
    endfunction

    task automatic pulse_fs(input bit b);
        if (b) fs_b = 1'b1;
        else   fs_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
        fs_b = 1'b0;
    endtask

    task automatic send(input int v, input bit idle);
        int n = 0;
        if (idle) begin
            valid = 1'b0;
            @(negedge clk);
        end
        valid = 1'b1;
        px    = 8'(v);
        while (!cur_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic send_run(input int first, input int n, input bit idle);
        for (int i = 0; i < n; i++) send(first + i, idle);
    endtask

    task automatic wait_done(input bit b, input int d0);
        int n = 0;
        while ((b ? b_done_n : a_done_n) == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("done_timeout", n, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic cmp_q(input string tag, input bit b, input int base,
                         input int exp[$]);
        int sz = b ? qb.size() : qa.size();
        chk({tag, "_len"}, sz - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            int v = -1;
            if (base + i < sz) v = b ? qb[base + i] : qa[base + i];
            chk(tag, v, exp[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int e1[$];
        int e2[$];
        int ea[$];
        int base, d0, r0, v0;
        build(4, 3, 0, e1);
        build(5, 4, 0, e2);

        repeat (3) @(negedge clk);
        chk("rst_ready", a_ready, 0);
        chk("rst_start", a_start, 0);
        chk("rst_rdy", a_rdy, 0);
        chk("rst_done", a_done, 0);
        nreset = 1'b1;
        @(negedge clk);

        // frame start with no valid data: ready, but silent
        base = qa.size(); d0 = a_done_n; r0 = a_rise; v0 = a_bad;
        pulse_fs(1'b0);
        repeat (2) @(negedge clk);
        chk("idle_ready", a_ready, 1);
        chk("idle_nostrobe", qa.size() - base, 0);
        send_run(0, 12, 1'b0);
        wait_done(1'b0, d0);
        cmp_q("t1_seq", 1'b0, base, e1);
        chk("t1_done", a_done_n - d0, 1);
        chk("t1_rise", a_rise - r0, 1);
        chk("t1_lat", a_lat, 1);
        chk("t1_unframed", a_bad - v0, 0);
        chk("t1_end_ready", a_ready, 0);
        chk("t1_end_start", a_start, 0);

        // stalled upstream
        base = qa.size(); d0 = a_done_n; r0 = a_rise;
        pulse_fs(1'b0);
        send_run(0, 12, 1'b1);
        wait_done(1'b0, d0);
        cmp_q("t2_seq", 1'b0, base, e1);
        chk("t2_done", a_done_n - d0, 1);
        chk("t2_rise", a_rise - r0, 1);

        // 5x4 frame on the second instance
        sel = 1'b1;
        base = qb.size(); d0 = b_done_n; r0 = b_rise;
        pulse_fs(1'b1);
        send_run(0, 20, 1'b0);
        wait_done(1'b1, d0);
        cmp_q("t3_seq", 1'b1, base, e2);
        chk("t3_rise", b_rise - r0, 2);
        chk("t3_gap_ge2", int'(b_min >= 2), 1);
        chk("t3_done", b_done_n - d0, 1);
        sel = 1'b0;

        // reset during a burst
        pulse_fs(1'b0);
        send_run(0, 11, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_in_emit", a_rdy, 1);
        nreset = 1'b0;
        #1;
        chk("t4_rst_rdy", a_rdy, 0);
        chk("t4_rst_start", a_start, 0);
        chk("t4_rst_ready", a_ready, 0);
        chk("t4_rst_out", int'(a_out), 0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        base = qa.size(); d0 = a_done_n;
        pulse_fs(1'b0);
        send_run(0, 12, 1'b0);
        wait_done(1'b0, d0);
        cmp_q("t4_seq", 1'b0, base, e1);
        chk("t4_done", a_done_n - d0, 1);

        // frame_start while accepting row 1
        base = qa.size(); d0 = a_done_n;
        pulse_fs(1'b0);
        send_run(0, 6, 1'b0);
        pulse_fs(1'b0);
`ifdef SOBEL_FEEDER_ABORT_EN
        send_run(100, 12, 1'b0);
        build(4, 3, 100, ea);
`else
        send_run(6, 6, 1'b0);
        ea = e1;
`endif
        wait_done(1'b0, d0);
        cmp_q("t5_seq", 1'b0, base, ea);
        chk("t5_done", a_done_n - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_feeder.md
# sobel_feeder

Stream-to-window transmitter sitting between the grayscale conversion stage and `sobel_control`. It accepts a raster-ordered grayscale frame over a valid/ready handshake and buffers two previous rows. It then replays each 3x3 neighbourhood as the serialized pixel strobe protocol `sobel_control` consumes:
- nine pixels for the first window of an output row;
- three pixels (the new column) for each following window;
- `start_sobel_o` framing each output row.

## Interface
Parameters:
- `IMG_WIDTH`, 32, pixels per row; must be at least 3.
- `IMG_HEIGHT`, 24, rows per frame; must be at least 3.
- `PIXEL_WIDTH_OUT`, from parameters.svh (8), pixel width.

Ports:
- `clk_i`  in  1  single clock, all logic on rising edge.
- `nreset_i`  in  1  asynchronous, active-low reset.
- `frame_start_i`  in  1  one-cycle pulse; arms capture of a new frame.
- `px_valid_i`  in  1  input pixel valid.
- `px_i`  in  PIXEL_WIDTH_OUT  input grayscale pixel, raster order.
- `px_ready_o`  out  1  feeder can accept `px_i` this cycle.
- `start_sobel_o`  out  1  output-row framing to `sobel_control`.
- `px_rdy_o`  out  1  one-cycle strobe; `out_px_o` valid.
- `out_px_o`  out  PIXEL_WIDTH_OUT  serialized window pixel.
- `frame_done_o`  out  1  one-cycle pulse after the last window of a frame.

## Operation
- Handshake: a pixel transfers on a cycle where `px_valid_i` and `px_ready_o` are both high. `px_ready_o` is high only in ACCEPT. Upstream holds `px_i` while `px_valid_i` is high and `px_ready_o` is low.
- Counters: `col` and `row` track the position of the accepted pixel.
  - `col` wraps from IMG_WIDTH-1 to 0 and increments `row`.
  - Widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).
- Storage:
  - Two line buffers hold rows r-1 and r-2, register arrays with 3 combinational read ports.
  - A 2-entry shift register holds (r,c-2) and (r,c-1).
  - A row rotation at `col` wrap replaces the line-buffer copy.
- Window trigger: an accepted pixel with row ≥ 2 and col ≥ 2 completes a window.
- Emission for col == 2 (9 pixels, row-major): (r-2,c-2), (r-2,c-1), (r-2,c), (r-1,c-2), (r-1,c-1), (r-1,c), (r,c-2), (r,c-1), (r,c).
- Emission for col > 2 (3 pixels): (r-2,c), (r-1,c), (r,c).
- FSM states and transitions:
  - IDLE: → ACCEPT on `frame_start_i`; counters cleared.
  - ACCEPT: on a handshake completing a window → LEAD if col == 2, else → EMIT; otherwise stay.
  - LEAD: 1 cycle; raises `start_sobel_o`; → EMIT.
  - EMIT: one pixel per cycle; 9 or 3 pixels, then:
    - → GAP if col == IMG_WIDTH-1;
    - → ACCEPT otherwise.
  - GAP: exactly 2 cycles with `start_sobel_o` low, then:
    - → IDLE with `frame_done_o` pulse if row == IMG_HEIGHT-1;
    - → ACCEPT otherwise.
- `frame_start_i` outside IDLE is ignored (see Configuration).
- A frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0. Line buffers are not reset; the fill rows overwrite them.
- Reset asserted mid-frame: immediate return to IDLE; a new `frame_start_i` is required.
- All outputs are registered.
- Latency, col == 2 window accepted at edge T:
  - `start_sobel_o` goes high in cycle T+1.
  - `px_rdy_o` is high for cycles T+2..T+10.
- Latency, col > 2 window accepted at edge T: `px_rdy_o` is high for cycles T+1..T+3.
- `start_sobel_o` stays high from LEAD through the last strobe of the row, then is low at least 2 cycles.
- Steady-state throughput: 1 input pixel per 4 cycles. During fill (row < 2 or col < 2): 1 pixel per cycle.

## Configuration
- `SOBEL_FEEDER_ABORT_EN` defined:
  - `frame_start_i` in any state other than IDLE aborts the current frame.
  - Within 1 cycle: `start_sobel_o` and `px_rdy_o` deassert, counters clear, FSM enters ACCEPT.
  - No `frame_done_o` is pulsed for the aborted frame.
- `SOBEL_FEEDER_ABORT_EN` undefined: `frame_start_i` is ignored outside IDLE.

## Structure
- parameters.svh (shared): `IMG_WIDTH`/`IMG_HEIGHT` defaults, `PIXEL_WIDTH_OUT`, the feeder state enum typedef, emission counts 9 and 3 as named constants.
- Sub-module `sobel_line_buffer`: two-row storage with rotate-on-wrap and 3 column read ports; the FSM and serializer stay in `sobel_feeder`.

## Test plan
- W=4, H=3, pixels 0..11 with valid held high: accepting 10 → `start_sobel_o` rises, then strobes 0,1,2,4,5,6,8,9,10; accepting 11 → strobes 3,7,11; then 2-cycle low gap and one `frame_done_o`.
- Same frame with `px_valid_i` toggling every other cycle → identical output sequence, no duplicated or dropped strobes.
- W=5, H=4, sequential pixels → 6 windows total.
  - Row-1 windows start with 9-pixel bursts beginning at pixel 0.
  - Row-2 windows start with 9-pixel bursts beginning at pixel 5.
  - `start_sobel_o` drops ≥2 cycles between rows.
- `nreset_i` pulsed low during an EMIT burst → outputs 0 immediately; a new frame afterwards reproduces the first test's sequence exactly.
- `frame_start_i` during ACCEPT at row 1:
  - with `SOBEL_FEEDER_ABORT_EN` → the restarted frame's first strobe is new pixel (0,0);
  - without it → the original frame completes unchanged.
- `frame_start_i` with `px_valid_i` low → `px_ready_o` high and no strobes.
